// File: rtl/fp16_pkg.sv
// rtl/fp16_pkg.sv - FP16 field widths, constants and accumulator state encoding.
package fp16_pkg;

  localparam int FP16_W = 16;
  localparam int EXP_W  = 5;
  localparam int MAN_W  = 10;

  localparam logic [EXP_W-1:0]  EXP_MAX   = 5'h1F;
  localparam logic [FP16_W-1:0] FP16_ZERO = 16'h0000;

  typedef enum logic {
    ACC  = 1'b0,
    HOLD = 1'b1
  } state_e;

  function automatic logic [EXP_W-1:0] fp16_exp(input logic [FP16_W-1:0] w);
    return w[FP16_W-2 -: EXP_W];
  endfunction

endpackage

// File: rtl/fp16_class.sv
// rtl/fp16_class.sv - combinational FP16 classifier: exact zero, subnormal, all-ones exponent.
module fp16_class
  import fp16_pkg::*;
(
  input  logic [FP16_W-1:0] word,
  output logic              is_zero,
  output logic              is_sub,
  output logic              is_max_exp
);

  logic [EXP_W-1:0] exp_f;
  logic [MAN_W-1:0] man_f;

  always_comb begin
    exp_f      = fp16_exp(word);
    man_f      = word[MAN_W-1:0];
    is_zero    = (exp_f == '0) && (man_f == '0);
    is_sub     = (exp_f == '0) && (man_f != '0);
    is_max_exp = (exp_f == EXP_MAX);
  end

endmodule

// File: rtl/fp16_accum_seq.sv
// rtl/fp16_accum_seq.sv - streaming FP16 vector accumulator around an external adder.
// FP16_ACC_FTZ_EN: flush exponent-0 operands to +0 before they reach the adder.
module fp16_accum_seq #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [15:0]      in_data,
  input  logic             in_last,
  output logic [15:0]      add_a,
  output logic [15:0]      add_b,
  input  logic [15:0]      add_sum,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [15:0]      out_data,
  output logic [CNT_W-1:0] out_count,
  output logic             out_ovf,
  output logic             out_csat
);

  import fp16_pkg::*;

  state_e            state_q, state_d;
  logic [FP16_W-1:0] acc_q, acc_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic              ovf_q, ovf_d;
  logic              csat_q, csat_d;
  logic [FP16_W-1:0] out_data_q, out_data_d;
  logic [CNT_W-1:0]  out_count_q, out_count_d;
  logic              out_ovf_q, out_ovf_d;
  logic              out_csat_q, out_csat_d;

  logic sum_max_exp;
  logic unused_sum_zero;
  logic unused_sum_sub;

  fp16_class u_sum_class (
    .word       (add_sum),
    .is_zero    (unused_sum_zero),
    .is_sub     (unused_sum_sub),
    .is_max_exp (sum_max_exp)
  );

`ifdef FP16_ACC_FTZ_EN
  logic in_is_zero;
  logic in_is_sub;
  logic unused_in_max;

  fp16_class u_in_class (
    .word       (in_data),
    .is_zero    (in_is_zero),
    .is_sub     (in_is_sub),
    .is_max_exp (unused_in_max)
  );

  assign add_b = (in_is_zero || in_is_sub) ? FP16_ZERO : in_data;
`else
  assign add_b = in_data;
`endif

  assign add_a     = acc_q;
  assign in_ready  = (state_q == ACC);
  assign out_valid = (state_q == HOLD);
  assign out_data  = out_data_q;
  assign out_count = out_count_q;
  assign out_ovf   = out_ovf_q;
  assign out_csat  = out_csat_q;

  logic             beat;
  logic             count_sat;
  logic [CNT_W-1:0] count_inc;
  logic             ovf_inc;
  logic             csat_inc;

  always_comb begin
    state_d     = state_q;
    acc_d       = acc_q;
    count_d     = count_q;
    ovf_d       = ovf_q;
    csat_d      = csat_q;
    out_data_d  = out_data_q;
    out_count_d = out_count_q;
    out_ovf_d   = out_ovf_q;
    out_csat_d  = out_csat_q;

    beat      = in_valid && in_ready;
    count_sat = (count_q == {CNT_W{1'b1}});
    count_inc = count_sat ? count_q : count_q + CNT_W'(1);
    ovf_inc   = ovf_q | sum_max_exp;
    csat_inc  = csat_q | count_sat;

    case (state_q)
      ACC: begin
        if (beat) begin
          acc_d   = add_sum;
          count_d = count_inc;
          ovf_d   = ovf_inc;
          csat_d  = csat_inc;
          // Result registers capture the totals including the closing beat.
          if (in_last) begin
            out_data_d  = add_sum;
            out_count_d = count_inc;
            out_ovf_d   = ovf_inc;
            out_csat_d  = csat_inc;
            state_d     = HOLD;
          end
        end
      end
      HOLD: begin
        if (out_ready) begin
          state_d = ACC;
          acc_d   = FP16_ZERO;
          count_d = '0;
          ovf_d   = 1'b0;
          csat_d  = 1'b0;
        end
      end
      default: state_d = ACC;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ACC;
      acc_q       <= FP16_ZERO;
      count_q     <= '0;
      ovf_q       <= 1'b0;
      csat_q      <= 1'b0;
      out_data_q  <= FP16_ZERO;
      out_count_q <= '0;
      out_ovf_q   <= 1'b0;
      out_csat_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      acc_q       <= acc_d;
      count_q     <= count_d;
      ovf_q       <= ovf_d;
      csat_q      <= csat_d;
      out_data_q  <= out_data_d;
      out_count_q <= out_count_d;
      out_ovf_q   <= out_ovf_d;
      out_csat_q  <= out_csat_d;
    end
  end

endmodule

// File: tb/tb_fp16_accum_seq.sv
// tb/tb_fp16_accum_seq.sv - directed scoreboard bench for fp16_accum_seq (honours FP16_ACC_FTZ_EN).
module tb_fp16_accum_seq;

  localparam int CNT_W  = 8;
  localparam int CMAX   = (1 << CNT_W) - 1;
  localparam int BOUND  = 40;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic             rst, in_valid, in_ready, in_last, out_valid, out_ready, out_ovf, out_csat;
  logic [15:0]      in_data, add_a, add_b, add_sum, out_data;
  logic [CNT_W-1:0] out_count;

  logic        d2_in_valid, d2_in_ready, d2_in_last, d2_out_valid, d2_out_ready, d2_out_ovf, d2_out_csat;
  logic [15:0] d2_in_data, d2_add_a, d2_add_b, d2_add_sum, d2_out_data;
  logic [1:0]  d2_out_count;

  typedef struct {
    logic [15:0] data;
    int          count;
    logic        ovf;
    logic        csat;
  } res_t;

  res_t        sb[$];
  logic [15:0] m_acc;
  int          m_cnt;
  logic        m_ovf;
  int          errors = 0;
  int          checks = 0;

  function automatic real p2(input int k);
    real r = 1.0;
    if (k >= 0) for (int i = 0; i < k; i++) r = r * 2.0;
    else for (int i = 0; i < -k; i++) r = r / 2.0;
    return r;
  endfunction

  function automatic real to_real(input logic [15:0] h);
    int  e = int'(h[14:10]);
    real r;
    if (e == 0) r = real'(h[9:0]) * p2(-24);
    else r = (1.0 + real'(h[9:0]) / 1024.0) * p2(e - 15);
    return h[15] ? -r : r;
  endfunction

  function automatic logic [15:0] from_real(input real r);
    logic        s = (r < 0.0);
    real         a = s ? -r : r;
    int          e = 0;
    int          man;
    logic [15:0] h;
    if (a == 0.0) return 16'h0000;
    while (a >= p2(e + 1)) e++;
    while (a < p2(e)) e--;
    if (e > 15) return {s, 5'h1F, 10'h000};
    if (e < -14) begin
      man = $rtoi(a / p2(-24));
      h = {s, 5'd0, man[9:0]};
    end else begin
      man = $rtoi((a / p2(e) - 1.0) * 1024.0);
      h = {s, 5'(e + 15), man[9:0]};
    end
    return h;
  endfunction

  function automatic logic [15:0] fadd(input logic [15:0] a, input logic [15:0] b);
    return from_real(to_real(a) + to_real(b));
  endfunction

  function automatic logic [15:0] ftz(input logic [15:0] d);
`ifdef FP16_ACC_FTZ_EN
    return (d[14:10] == 5'd0) ? 16'h0000 : d;
`else
    return d;
`endif
  endfunction

  // Stand-in for the external combinational adder on both instances.
  assign add_sum    = fadd(add_a, add_b);
  assign d2_add_sum = fadd(d2_add_a, d2_add_b);

  fp16_accum_seq #(.CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .in_last(in_last), .add_a(add_a), .add_b(add_b), .add_sum(add_sum),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_count(out_count), .out_ovf(out_ovf), .out_csat(out_csat)
  );

  fp16_accum_seq #(.CNT_W(2)) dut2 (
    .clk(clk), .rst(rst), .in_valid(d2_in_valid), .in_ready(d2_in_ready), .in_data(d2_in_data),
    .in_last(d2_in_last), .add_a(d2_add_a), .add_b(d2_add_b), .add_sum(d2_add_sum),
    .out_valid(d2_out_valid), .out_ready(d2_out_ready), .out_data(d2_out_data),
    .out_count(d2_out_count), .out_ovf(d2_out_ovf), .out_csat(d2_out_csat)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  task automatic model_clear();
    m_acc = 16'h0000;
    m_cnt = 0;
    m_ovf = 1'b0;
  endtask

  task automatic send(input logic [15:0] d, input logic last);
    res_t e;
    int   n = 0;
    in_valid = 1'b1;
    in_data  = d;
    in_last  = last;
    while (!in_ready && n < BOUND) begin
      @(posedge clk); #1;
      n++;
    end
    if (!in_ready) check("send_timeout", 32'd0, 32'd1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    in_last  = 1'b0;
    m_acc = fadd(m_acc, ftz(d));
    m_cnt++;
    m_ovf = m_ovf | (m_acc[14:10] == 5'h1F);
    if (last) begin
      e.data  = m_acc;
      e.count = (m_cnt > CMAX) ? CMAX : m_cnt;
      e.ovf   = m_ovf;
      e.csat  = (m_cnt > CMAX);
      sb.push_back(e);
      model_clear();
    end
  endtask

  task automatic collect(input string tag, input int stall);
    res_t e;
    int   n = 0;
    while (!out_valid && n < BOUND) begin
      @(posedge clk); #1;
      n++;
    end
    check({tag, "_valid"}, 32'(out_valid), 32'd1);
    if (sb.size() == 0) begin
      check({tag, "_sb_empty"}, 32'd0, 32'd1);
    end else begin
      e = sb.pop_front();
      check({tag, "_data"}, 32'(out_data), 32'(e.data));
      check({tag, "_count"}, 32'(out_count), 32'(e.count));
      check({tag, "_ovf"}, 32'(out_ovf), 32'(e.ovf));
      check({tag, "_csat"}, 32'(out_csat), 32'(e.csat));
      for (int i = 0; i < stall; i++) begin
        @(posedge clk); #1;
        check({tag, "_hold_ready"}, 32'(in_ready), 32'd0);
        check({tag, "_hold_valid"}, 32'(out_valid), 32'd1);
        check({tag, "_hold_data"}, 32'(out_data), 32'(e.data));
        check({tag, "_hold_count"}, 32'(out_count), 32'(e.count));
      end
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    check({tag, "_drop_valid"}, 32'(out_valid), 32'd0);
    check({tag, "_back_ready"}, 32'(in_ready), 32'd1);
  endtask

  initial begin
    int n;
    rst = 1'b1; in_valid = 1'b0; in_data = '0; in_last = 1'b0; out_ready = 1'b0;
    d2_in_valid = 1'b0; d2_in_data = '0; d2_in_last = 1'b0; d2_out_ready = 1'b0;
    model_clear();
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;

    check("rst_valid", 32'(out_valid), 32'd0);
    check("rst_ready", 32'(in_ready), 32'd1);
    check("rst_data", 32'(out_data), 32'd0);
    check("rst_count", 32'(out_count), 32'd0);
    check("rst_acc", 32'(add_a), 32'd0);

    // 1) three beats, no stalls
    send(16'h3C00, 1'b0);
    send(16'h4000, 1'b0);
    check("t1_pre_valid", 32'(out_valid), 32'd0);
    send(16'h4200, 1'b1);
    check("t1_lat_valid", 32'(out_valid), 32'd1);
    check("t1_const_data", 32'(out_data), 32'h4600);
    collect("t1", 0);

    // 2) single beat vector
    send(16'h3E00, 1'b1);
    check("t2_const_data", 32'(out_data), 32'h3E00);
    collect("t2", 0);

    // 3) output back-pressure with a beat waiting upstream
    send(16'h3C00, 1'b0);
    send(16'h4000, 1'b1);
    in_valid = 1'b1; in_data = 16'h3800; in_last = 1'b1;
    collect("t3a", 5);
    send(16'h3800, 1'b1);
    check("t3_const_data", 32'(out_data), 32'h3800);
    collect("t3b", 0);

    // 4) overflow flag, then cleared on next vector
    send(16'h7800, 1'b0);
    send(16'h7800, 1'b1);
    check("t4_const_data", 32'(out_data), 32'h7C00);
    check("t4_const_ovf", 32'(out_ovf), 32'd1);
    collect("t4a", 0);
    send(16'h3C00, 1'b1);
    check("t4_const_ovf_clr", 32'(out_ovf), 32'd0);
    collect("t4b", 0);

    // 5) subnormal operand
    send(16'h0001, 1'b1);
`ifdef FP16_ACC_FTZ_EN
    check("t5_const_data", 32'(out_data), 32'h0000);
`else
    check("t5_const_data", 32'(out_data), 32'h0001);
`endif
    collect("t5", 0);

    // 6) reset mid-vector
    send(16'h4000, 1'b0);
    send(16'h4000, 1'b0);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    model_clear();
    check("t6_rst_valid", 32'(out_valid), 32'd0);
    check("t6_rst_data", 32'(out_data), 32'd0);
    check("t6_rst_count", 32'(out_count), 32'd0);
    check("t6_rst_ovf", 32'(out_ovf), 32'd0);
    check("t6_rst_csat", 32'(out_csat), 32'd0);
    check("t6_rst_acc", 32'(add_a), 32'd0);
    send(16'h4000, 1'b1);
    check("t6_const_data", 32'(out_data), 32'h4000);
    check("t6_const_count", 32'(out_count), 32'd1);
    collect("t6", 0);

    // 6b) CNT_W=2 instance: four zero beats saturate the counter
    for (int i = 0; i < 4; i++) begin
      d2_in_valid = 1'b1;
      d2_in_data  = 16'h0000;
      d2_in_last  = (i == 3);
      n = 0;
      while (!d2_in_ready && n < BOUND) begin
        @(posedge clk); #1;
        n++;
      end
      if (!d2_in_ready) check("d2_send_timeout", 32'd0, 32'd1);
      @(posedge clk); #1;
    end
    d2_in_valid = 1'b0;
    d2_in_last  = 1'b0;
    check("d2_valid", 32'(d2_out_valid), 32'd1);
    check("d2_data", 32'(d2_out_data), 32'h0000);
    check("d2_count", 32'(d2_out_count), 32'd3);
    check("d2_csat", 32'(d2_out_csat), 32'd1);
    check("d2_ovf", 32'(d2_out_ovf), 32'd0);
    d2_out_ready = 1'b1;
    @(posedge clk); #1;
    d2_out_ready = 1'b0;
    check("d2_drop_valid", 32'(d2_out_valid), 32'd0);

    check("sb_drained", 32'(sb.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
